uart_rx_framed: RTL

//  Parametrised UART receiver: start/data/parity/stop framing, mid-bit sampling,

---
 rtl/uart_rx_framed.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/uart_rx_framed.sv
// UART receiver with start/data/parity/stop framing, mid-bit sampling,
// false-start rejection, and parity/framing error flags.
//
// Output handshake: o_valid is a single-cycle pulse with no ready/backpressure.
// o_data, o_parity_err and o_frame_err are meaningful only while o_valid is high.
// o_data holds its value until the next pulse, and the error flags read 0
// between pulses. o_dbg_state exposes the FSM state for observation.
module uart_rx_framed #(
  parameter int CLK_DIV     = 10417,
  parameter int DATA_BITS   = 8,
  parameter int PARITY_MODE = 0,
  parameter int STOP_BITS   = 1
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_rx,
  output logic [DATA_BITS-1:0] o_data,
  output logic                 o_valid,
  output logic                 o_parity_err,
  output logic                 o_frame_err,
  output logic                 o_busy,
  output logic [2:0]           o_dbg_state
);

  localparam int CW   = $clog2(CLK_DIV);
  localparam int HALF = CLK_DIV / 2;
  localparam int BW   = 4;
  localparam logic [CW-1:0] HALF_M1   = CW'(HALF - 1);
  localparam logic [CW-1:0] FULL_M1   = CW'(CLK_DIV - 1);
  localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  state_t               state_q, state_d;
  logic                 rx_s1_q, rx_s1_d, rx_s2_q, rx_s2_d;
  logic [1:0]           warm_q, warm_d;   // synchroniser fill count after reset
  logic                 armed_q, armed_d; // line seen high while idle
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [BW-1:0]        bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_q, par_d;
  logic                 perr_q, perr_d;
  logic                 ferr_q, ferr_d;
  logic [DATA_BITS-1:0] data_out_q, data_out_d;
  logic                 valid_q, valid_d;
  logic                 perr_out_q, perr_out_d;
  logic                 ferr_out_q, ferr_out_d;
  logic                 rx;
  logic                 sample;

  assign rx     = rx_s2_q;
  assign sample = (cnt_q == FULL_M1);

  // Next-state, counters, shift register and output registers.
  always_comb begin
    state_d    = state_q;
    rx_s1_d    = i_rx;
    rx_s2_d    = rx_s1_q;
    warm_d     = (warm_q == 2'd2) ? warm_q : warm_q + 2'd1;
    armed_d    = armed_q;
    cnt_d      = cnt_q + CW'(1);
    bit_d      = bit_q;
    shift_d    = shift_q;
    par_d      = par_q;
    perr_d     = perr_q;
    ferr_d     = ferr_q;
    data_out_d = data_out_q;
    valid_d    = 1'b0;
    perr_out_d = 1'b0;
    ferr_out_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        // A start needs the line to have been seen high first, so a line
        // held low out of reset or after a break never begins a frame.
        if (armed_q && !rx) begin
          state_d = S_START;
          armed_d = 1'b0;
        end else begin
          armed_d = armed_q | ((warm_q == 2'd2) & rx);
        end
      end
      S_START: begin
        if (cnt_q == HALF_M1) begin
          if (rx) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_DATA;
            cnt_d   = '0;
            bit_d   = '0;
            shift_d = '0;
            par_d   = 1'b0;
            perr_d  = 1'b0;
            ferr_d  = 1'b0;
          end
        end
      end
      S_DATA: begin
        if (sample) begin
          cnt_d   = '0;
          shift_d = {rx, shift_q[DATA_BITS-1:1]};
          par_d   = par_q ^ rx;
          bit_d   = bit_q + BW'(1);
          if (bit_q == DATA_LAST) begin
            bit_d   = '0;
            state_d = (PARITY_MODE != 0) ? S_PARITY : S_STOP;
          end
        end
      end
      S_PARITY: begin
        if (sample) begin
          cnt_d   = '0;
          perr_d  = ((par_q ^ rx) != (PARITY_MODE == 1));
          state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (sample) begin
          cnt_d  = '0;
          ferr_d = ferr_q | ~rx;
          bit_d  = bit_q + BW'(1);
          if (bit_q == STOP_LAST) begin
            // Return to idle at mid-stop so a back-to-back start is caught.
            state_d    = S_IDLE;
            bit_d      = '0;
            valid_d    = 1'b1;
            data_out_d = shift_q;
            perr_out_d = perr_q;
            ferr_out_d = ferr_q | ~rx;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and data registers with synchronous active-high reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= S_IDLE;
      rx_s1_q    <= 1'b1;
      rx_s2_q    <= 1'b1;
      warm_q     <= 2'd0;
      armed_q    <= 1'b0;
      cnt_q      <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      par_q      <= 1'b0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      data_out_q <= '0;
      valid_q    <= 1'b0;
      perr_out_q <= 1'b0;
      ferr_out_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      rx_s1_q    <= rx_s1_d;
      rx_s2_q    <= rx_s2_d;
      warm_q     <= warm_d;
      armed_q    <= armed_d;
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      par_q      <= par_d;
      perr_q     <= perr_d;
      ferr_q     <= ferr_d;
      data_out_q <= data_out_d;
      valid_q    <= valid_d;
      perr_out_q <= perr_out_d;
      ferr_out_q <= ferr_out_d;
    end
  end

  assign o_data       = data_out_q;
  assign o_valid      = valid_q;
  assign o_parity_err = perr_out_q;
  assign o_frame_err  = ferr_out_q;
  assign o_busy       = (state_q != S_IDLE);
  assign o_dbg_state  = state_q;

endmodule
